// File: rtl/gpio_axil_pkg.sv
// Shared definitions for the GPIO AXI4-Lite arbiter: register map, response codes, FSM encoding.
// Pure declarations, no latency or flow control of its own.
package gpio_axil_pkg;

    localparam logic [7:0] GPIO_OUT      = 8'h00;
    localparam logic [7:0] GPIO_OE       = 8'h04;
    localparam logic [7:0] GPIO_IN       = 8'h08;
    localparam logic [7:0] GPIO_INT_EN   = 8'h0C;
    localparam logic [7:0] GPIO_INT_STAT = 8'h10;
    localparam logic [7:0] GPIO_INT_CLR  = 8'h14;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] TIMEOUT_RESP = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first request after ptr, wrapping.
// Zero latency; no state, the caller owns the pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    // cand[k] is the requester examined at search step k (ptr+1 first)
    logic [IW-1:0] cand [N];

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand[k] = IW'((int'(ptr) + k + 1) % N);
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                gnt          = '0;
                gnt[cand[k]] = 1'b1;
                gnt_idx      = cand[k];
            end
        end
    end

endmodule

// File: rtl/gpio_axil_arbiter.sv
// Round-robin front end sharing one AXI4-Lite master among NUM_REQ requesters, one transaction at a time.
// Grant in IDLE, response pulse to the owner after the AXI exchange or after TIMEOUT wait cycles.
module gpio_axil_arbiter
    import gpio_axil_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_wstrb,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int         IW  = $clog2(NUM_REQ);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t              state;
    logic [IW-1:0]       ptr, owner, gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          tmo_cnt;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic [3:0]          sel_wstrb;
    logic                aw_hs, w_hs, tmo_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_wstrb = req_wstrb[i*4 +: 4];
            end
        end
    end

    // Gated by rst_n so a requester holding req_valid through reset sees no ready
    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
    assign busy      = (state != IDLE);
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign tmo_hit   = (tmo_cnt == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            owner     <= '0;
            addr_q    <= '0;
            tmo_cnt   <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            rsp_valid <= '0;
            if (state inside {WR_AW_W, WR_B, RD_AR, RD_R}) tmo_cnt <= tmo_cnt + 8'd1;

            if (state != IDLE && state != RESP && tmo_hit) begin
                m_awvalid <= 1'b0;
                m_wvalid  <= 1'b0;
                m_bready  <= 1'b0;
                m_arvalid <= 1'b0;
                m_rready  <= 1'b0;
                rsp_resp  <= TIMEOUT_RESP;
                rsp_rdata <= '0;
                rsp_valid <= NUM_REQ'(1) << owner;
                state     <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        if (|req_valid) begin
                            owner   <= gnt_idx;
                            ptr     <= gnt_idx;
                            tmo_cnt <= '0;
                            addr_q  <= sel_addr;
                            m_wdata <= sel_wdata;
                            m_wstrb <= sel_wstrb;
                            if (sel_write) begin
                                m_awvalid <= 1'b1;
                                m_wvalid  <= 1'b1;
                                state     <= WR_AW_W;
                            end else begin
                                m_arvalid <= 1'b1;
                                m_rready  <= 1'b1;
                                state     <= RD_AR;
                            end
                        end
                    end
                    WR_AW_W: begin
                        if (aw_hs) m_awvalid <= 1'b0;
                        if (w_hs)  m_wvalid  <= 1'b0;
                        // AW and W may finish in different cycles; leave once both are done
                        if ((aw_hs || !m_awvalid) && (w_hs || !m_wvalid)) begin
                            m_bready <= 1'b1;
                            state    <= WR_B;
                        end
                    end
                    WR_B: begin
                        if (m_bvalid) begin
                            m_bready  <= 1'b0;
                            rsp_resp  <= m_bresp;
                            rsp_rdata <= '0;
                            rsp_valid <= NUM_REQ'(1) << owner;
                            state     <= RESP;
                        end
                    end
                    RD_AR: begin
                        if (m_arready) begin
                            m_arvalid <= 1'b0;
                            if (m_rvalid) begin
                                m_rready  <= 1'b0;
                                rsp_resp  <= m_rresp;
                                rsp_rdata <= m_rdata;
                                rsp_valid <= NUM_REQ'(1) << owner;
                                state     <= RESP;
                            end else begin
                                state <= RD_R;
                            end
                        end
                    end
                    RD_R: begin
                        if (m_rvalid) begin
                            m_rready  <= 1'b0;
                            rsp_resp  <= m_rresp;
                            rsp_rdata <= m_rdata;
                            rsp_valid <= NUM_REQ'(1) << owner;
                            state     <= RESP;
                        end
                    end
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
